// File: rtl/axis_dac_fmt_pkg.sv
// Shared definitions for the axis_dac_fmt output conditioner.
//   CLIP_CNT_W : width of the clip counter
//   max_shamt  : largest effective shift for a given SCALE / SHIFT_W
//   sat_sel    : classifies a lane value against the signed output range
package axis_dac_fmt_pkg;

  localparam int CLIP_CNT_W = 16;

  function automatic int max_shamt(input int scale, input int shift_w);
    return scale + 2 * ((1 << shift_w) - 1);
  endfunction

  // Largest effective shift with the default SCALE=12, SHIFT_W=4.
  localparam int MAX_SHAMT = max_shamt(12, 4);

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_sel_t;

  // Reports whether v lies above, below or inside the signed out_w-bit range.
  // The lane uses this both to pick a clamp value and to raise its clip flag,
  // so the flag is identical in saturate and wrap modes.
  function automatic sat_sel_t sat_sel(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/axis_dac_fmt_lane.sv
// Combinational datapath for one lane.
//   Stage 1 : x, shamt, round_en -> s1_y (rounded arithmetic shift, IN_W+1 bits)
//   Stage 2 : s1_q, sat_en       -> s2_y (offset binary), s2_clip
// The two stages are independent; the registers between them live in the top.
module axis_dac_fmt_lane
  import axis_dac_fmt_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 6
) (
  input  logic [IN_W-1:0]    x,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               round_en,
  output logic [IN_W:0]      s1_y,
  input  logic [IN_W:0]      s1_q,
  input  logic               sat_en,
  output logic [OUT_W-1:0]   s2_y,
  output logic               s2_clip
);

  localparam logic signed [IN_W:0] ONE = 1;

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] sum;

  // The extra bit gives headroom for the rounding add: with shamt <= IN_W the
  // half-LSB term is at most 2^(IN_W-1), so the sum cannot overflow.
  always_comb begin
    ext = {x[IN_W-1], x};
    rnd = '0;
    if (round_en && (shamt != '0)) rnd = ONE << (shamt - 1'b1);
    sum = ext + rnd;
    if (int'(shamt) > IN_W) s1_y = {(IN_W + 1){ext[IN_W]}};
    else                    s1_y = sum >>> shamt;
  end

  sat_sel_t         sel;
  logic [OUT_W-1:0] y;

  always_comb begin
    sel = sat_sel(64'($signed(s1_q)), OUT_W);
    y   = s1_q[OUT_W-1:0];
    if (sat_en && (sel == SAT_HI))      y = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (sat_en && (sel == SAT_LO)) y = {1'b1, {(OUT_W - 1){1'b0}}};
    s2_clip = (sel != SAT_NONE);
    // MSB inversion turns two's complement into offset binary.
    s2_y = {~y[OUT_W-1], y[OUT_W-2:0]};
  end

endmodule

// File: rtl/axis_dac_fmt.sv
// AXI-Stream conditioner between the FIR output and the DAC.
//   s00_axis_* : NUM_CH signed IN_W-bit samples per beat, tlast marks frame end
//   m00_axis_* : NUM_CH offset-binary OUT_W-bit samples, tlast forwarded
//   shift      : runtime shift, latched between frames (shamt = SCALE + 2*shift)
//   round_en   : round-half-up before shifting, sampled on input acceptance
//   sat_en     : saturate (1) or wrap (0), sampled when a beat enters stage 2
//   clip_clr   : synchronous clear of clip_count, wins over an increment
//   clip_count : saturating count of beats with at least one clipped lane
//
// Handshake: a beat moves across an interface on a clock edge where valid and
// ready are both high. Valid never depends on ready; once m00_axis_tvalid is
// high, data and tlast hold until the beat is taken. s00_axis_tready is
// combinational from m00_axis_tready so a full pipe still streams 1 beat/cycle.
module axis_dac_fmt
  import axis_dac_fmt_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int NUM_CH  = 1,
  parameter int SCALE   = 12,
  parameter int SHIFT_W = 4
) (
  input  logic                      s00_axis_aclk,
  input  logic                      s00_axis_aresetn,
  input  logic [NUM_CH*IN_W-1:0]    s00_axis_tdata,
  input  logic                      s00_axis_tvalid,
  input  logic                      s00_axis_tlast,
  output logic                      s00_axis_tready,
  output logic [NUM_CH*OUT_W-1:0]   m00_axis_tdata,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  output logic [NUM_CH*OUT_W/8-1:0] m00_axis_tstrb,
  input  logic                      m00_axis_tready,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic                      round_en,
  input  logic                      sat_en,
  input  logic                      clip_clr,
  output logic [CLIP_CNT_W-1:0]     clip_count
);

  localparam int MAX_SH  = max_shamt(SCALE, SHIFT_W);
  localparam int SHAMT_W = $clog2(MAX_SH + 1);
  localparam int S1_W    = IN_W + 1;

  logic                      v1_q, v1_d, last1_q, last1_d;
  logic [NUM_CH*S1_W-1:0]    s1_q, s1_d;
  logic                      v2_q, v2_d, last2_q, last2_d;
  logic [NUM_CH*OUT_W-1:0]   data2_q, data2_d;
  logic [CLIP_CNT_W-1:0]     clip_cnt_q, clip_cnt_d;
  logic                      in_frame_q, in_frame_d;
  logic [SHIFT_W-1:0]        shift_active_q, shift_active_d;

  logic [SHAMT_W-1:0]        shamt;
  logic [NUM_CH*S1_W-1:0]    s1_y;
  logic [NUM_CH*OUT_W-1:0]   s2_y;
  logic [NUM_CH-1:0]         clip;
  logic                      adv1, adv2, accept, load2;

  assign shamt = SHAMT_W'(SCALE) + SHAMT_W'({shift_active_q, 1'b0});

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    axis_dac_fmt_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHAMT_W (SHAMT_W)
    ) u_lane (
      .x        (s00_axis_tdata[k*IN_W +: IN_W]),
      .shamt    (shamt),
      .round_en (round_en),
      .s1_y     (s1_y[k*S1_W +: S1_W]),
      .s1_q     (s1_q[k*S1_W +: S1_W]),
      .sat_en   (sat_en),
      .s2_y     (s2_y[k*OUT_W +: OUT_W]),
      .s2_clip  (clip[k])
    );
  end

  always_comb begin
    adv2   = !v2_q || m00_axis_tready;
    adv1   = !v1_q || adv2;
    accept = s00_axis_tvalid && adv1;
    load2  = adv2 && v1_q;

    v1_d           = v1_q;
    last1_d        = last1_q;
    s1_d           = s1_q;
    v2_d           = v2_q;
    last2_d        = last2_q;
    data2_d        = data2_q;
    clip_cnt_d     = clip_cnt_q;
    in_frame_d     = in_frame_q;
    shift_active_d = shift_active_q;

    if (accept) in_frame_d = !s00_axis_tlast;
    // Follow the control input whenever the next cycle is between frames, so
    // the first beat of a frame sees the latest value and the rest reuse it.
    if (!in_frame_d) shift_active_d = shift;

    if (adv1) begin
      v1_d = s00_axis_tvalid;
      if (s00_axis_tvalid) begin
        s1_d    = s1_y;
        last1_d = s00_axis_tlast;
      end
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        data2_d = s2_y;
        last2_d = last1_q;
      end
    end

    if (clip_clr)                                  clip_cnt_d = '0;
    else if (load2 && (|clip) && (clip_cnt_q != '1)) clip_cnt_d = clip_cnt_q + 1'b1;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      v1_q           <= 1'b0;
      last1_q        <= 1'b0;
      s1_q           <= '0;
      v2_q           <= 1'b0;
      last2_q        <= 1'b0;
      data2_q        <= '0;
      clip_cnt_q     <= '0;
      in_frame_q     <= 1'b0;
      shift_active_q <= '0;
    end else begin
      v1_q           <= v1_d;
      last1_q        <= last1_d;
      s1_q           <= s1_d;
      v2_q           <= v2_d;
      last2_q        <= last2_d;
      data2_q        <= data2_d;
      clip_cnt_q     <= clip_cnt_d;
      in_frame_q     <= in_frame_d;
      shift_active_q <= shift_active_d;
    end
  end

  assign s00_axis_tready = adv1;
  assign m00_axis_tdata  = data2_q;
  assign m00_axis_tvalid = v2_q;
  assign m00_axis_tlast  = last2_q;
  assign m00_axis_tstrb  = '1;
  assign clip_count      = clip_cnt_q;

endmodule

// File: tb/tb_axis_dac_fmt.sv
// Self-checking bench for axis_dac_fmt with two lanes. A reference model
// computes each lane from integer arithmetic and a scoreboard queue holds the
// expected output beats in order.
module tb_axis_dac_fmt;

  localparam int IN_W    = 32;
  localparam int OUT_W   = 8;
  localparam int NUM_CH  = 2;
  localparam int SCALE   = 12;
  localparam int SHIFT_W = 4;
  localparam int EW      = NUM_CH * OUT_W + 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CH*IN_W-1:0]    s_tdata;
  logic                      s_tvalid;
  logic                      s_tlast;
  logic                      s_tready;
  logic [NUM_CH*OUT_W-1:0]   m_tdata;
  logic                      m_tvalid;
  logic                      m_tlast;
  logic [NUM_CH*OUT_W/8-1:0] m_tstrb;
  logic                      m_tready;
  logic [SHIFT_W-1:0]        shift;
  logic                      round_en;
  logic                      sat_en;
  logic                      clip_clr;
  logic [15:0]               clip_count;

  axis_dac_fmt #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .SCALE(SCALE), .SHIFT_W(SHIFT_W)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (s_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tready  (m_tready),
    .shift            (shift),
    .round_en         (round_en),
    .sat_en           (sat_en),
    .clip_clr         (clip_clr),
    .clip_count       (clip_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {clip, offset-binary byte} for one lane.
  function automatic logic [8:0] lane_ref(input int x, input int s, input bit rnd, input bit sat);
    longint v;
    bit     clp;
    logic [7:0] y;
    if (s > IN_W) begin
      v = (x < 0) ? -64'sd1 : 64'sd0;
    end else begin
      v = longint'(x);
      if (rnd && s > 0) v = v + (longint'(1) <<< (s - 1));
      v = v >>> s;
    end
    clp = (v > 127) || (v < -128);
    if (sat && v > 127) v = 127;
    else if (sat && v < -128) v = -128;
    y = 8'(v) ^ 8'h80;
    return {clp, y};
  endfunction

  logic [EW-1:0]      exp_q[$];
  int                 acc_cyc_q[$];
  bit                 m_in_frame;
  logic [SHIFT_W-1:0] m_shift;
  int                 m_clip;
  int                 cyc;
  int                 last_lat;
  int                 n_out;
  logic [EW-1:0]      last_out;
  bit                 hold_pend;
  logic [EW-1:0]      hold_val;

  // Monitor: evaluated on the falling edge for the handshake of the next
  // rising edge, while all inputs and outputs are stable.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [8:0]    r;
    bit            any_clip;
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
      m_in_frame = 0;
      m_shift    = '0;
      m_clip     = 0;
      hold_pend  = 0;
    end else begin
      cyc++;
      check_eq("s_tready", 64'(s_tready), 64'(!(exp_q.size() == 2 && !m_tready)));
      if (hold_pend) begin
        check_eq("hold_valid", 64'(m_tvalid), 64'd1);
        check_eq("hold_data", 64'({m_tlast, m_tdata}), 64'(hold_val));
      end
      hold_pend = 0;
      if (m_tvalid) begin
        if (m_tready) begin
          check_eq("out_present", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("out_beat", 64'({m_tlast, m_tdata}), 64'(e));
            last_out = {m_tlast, m_tdata};
            last_lat = cyc - acc_cyc_q.pop_front();
            n_out++;
          end
        end else begin
          hold_pend = 1;
          hold_val  = {m_tlast, m_tdata};
        end
      end
      if (clip_clr) m_clip = 0;
      if (s_tvalid && s_tready) begin
        any_clip = 0;
        e = '0;
        e[EW-1] = s_tlast;
        for (int k = 0; k < NUM_CH; k++) begin
          r = lane_ref(int'(s_tdata[k*IN_W +: IN_W]), SCALE + 2 * int'(m_shift), round_en, sat_en);
          e[k*OUT_W +: OUT_W] = r[7:0];
          any_clip |= r[8];
        end
        exp_q.push_back(e);
        acc_cyc_q.push_back(cyc);
        if (any_clip && m_clip < 65535) m_clip++;
        m_in_frame = !s_tlast;
      end
      if (!m_in_frame) m_shift = shift;
    end
  end

  // ---------------- downstream ready / shift drivers ----------------
  int                 rdy_mode;   // 0 always ready, 1 fixed pattern, 2 random
  logic [7:0]         rdy_pat = 8'b1001_0010;
  logic [2:0]         pat_i   = '0;
  bit                 shift_rand;
  logic [SHIFT_W-1:0] shift_set;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       begin m_tready = rdy_pat[pat_i]; pat_i = pat_i + 3'd1; end
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    shift = shift_rand ? SHIFT_W'($urandom_range(0, 15)) : shift_set;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [31:0] x0, input logic [31:0] x1, input logic last);
    bit acc;
    acc      = 0;
    s_tvalid = 1'b1;
    s_tdata  = {x1, x0};
    s_tlast  = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
    end
    if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_tvalid) && i < 400) begin
      @(negedge clk);
      i++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(input logic [31:0] x0, input logic [31:0] x1);
    drive_beat(x0, x1, 1'b1);
    s_tvalid = 1'b0;
    drain();
  endtask

  function automatic logic [31:0] rnd_x();
    return 32'($signed($urandom) >>> $urandom_range(0, 24));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int start;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    round_en = 1'b0; sat_en = 1'b1; clip_clr = 1'b0;
    rdy_mode = 0; shift_rand = 0; shift_set = '0; m_tready = 1'b1; shift = '0;
    cyc = 0; n_out = 0; last_lat = 0; last_out = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_tdata", 64'(m_tdata), 64'd0);
    check_eq("rst_tlast", 64'(m_tlast), 64'd0);
    check_eq("rst_clip", 64'(clip_count), 64'd0);
    check_eq("tstrb", 64'(m_tstrb), 64'h3);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic conversion and latency
    one_beat(32'h0000_1000, 32'hFFFF_F000);
    check_eq("basic_pos", 64'(last_out[7:0]), 64'h81);
    check_eq("basic_neg", 64'(last_out[15:8]), 64'h7F);
    check_eq("latency", 64'(last_lat), 64'd2);
    one_beat(32'h0, 32'h0000_1000);
    check_eq("basic_zero", 64'(last_out[7:0]), 64'h80);

    // saturation and wrap, clip counting
    one_beat(32'h0008_0000, 32'h0);
    check_eq("sat_hi", 64'(last_out[7:0]), 64'hFF);
    check_eq("clip_1", 64'(clip_count), 64'd1);
    one_beat(32'hFFF0_0000, 32'h0);
    check_eq("sat_lo", 64'(last_out[7:0]), 64'h00);
    check_eq("clip_2", 64'(clip_count), 64'd2);
    sat_en = 1'b0;
    one_beat(32'h0008_0000, 32'h0);
    check_eq("wrap", 64'(last_out[7:0]), 64'h00);
    check_eq("clip_3", 64'(clip_count), 64'd3);
    sat_en = 1'b1;

    // rounding
    round_en = 1'b1;
    one_beat(32'h0000_0800, 32'h0000_07FF);
    check_eq("round_on", 64'(last_out[7:0]), 64'h81);
    check_eq("round_below", 64'(last_out[15:8]), 64'h80);
    round_en = 1'b0;
    one_beat(32'h0000_0800, 32'h0);
    check_eq("round_off", 64'(last_out[7:0]), 64'h80);

    // frame-coherent shift
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
    shift_set = 4'd2;
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b1);
    s_tvalid = 1'b0;
    drain();
    check_eq("frame_hold", 64'(last_out), 64'({1'b1, 8'h90, 8'h90}));
    one_beat(32'h0001_0000, 32'h0);
    check_eq("frame_next", 64'(last_out[7:0]), 64'h81);
    shift_set = 4'd0;
    repeat (2) @(posedge clk); #1;

    // backpressure: ready low 5 of 8 cycles
    rdy_mode = 1;
    start = n_out;
    for (int i = 0; i < 10; i++) drive_beat(rnd_x(), rnd_x(), (i == 4 || i == 9));
    s_tvalid = 1'b0;
    drain();
    check_eq("bp_count", 64'(n_out - start), 64'd10);
    rdy_mode = 0;

    // both lanes clip -> one increment
    clip_clr = 1'b1; @(posedge clk); #1; clip_clr = 1'b0;
    one_beat(32'h0008_0000, 32'hFFF0_0000);
    check_eq("dual_lanes", 64'(last_out[15:0]), 64'h00FF);
    check_eq("dual_clip", 64'(clip_count), 64'd1);

    // clear in the same cycle the clipping beat enters stage 2
    s_tvalid = 1'b1; s_tdata = {32'h0, 32'h0008_0000}; s_tlast = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0; clip_clr = 1'b1;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    drain();
    check_eq("clr_vs_clip", 64'(clip_count), 64'd0);

    // randomized streams with a per-cycle random shift input
    shift_rand = 1;
    for (int r = 0; r < 8; r++) begin
      rdy_mode = (r % 2 == 0) ? 2 : 0;
      round_en = 1'($urandom_range(0, 1));
      sat_en   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 30; i++) drive_beat(rnd_x(), rnd_x(), ($urandom_range(0, 3) == 0));
      s_tvalid = 1'b0;
      drain();
      check_eq("rand_clip", 64'(clip_count), 64'(m_clip));
    end
    shift_rand = 0;
    round_en = 1'b0;
    sat_en = 1'b1;

    // reset in the middle of a frame
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) drive_beat(rnd_x(), rnd_x(), 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("mid_rst_tdata", 64'(m_tdata), 64'd0);
    check_eq("mid_rst_clip", 64'(clip_count), 64'd0);
    s_tvalid = 1'b0;
    shift_set = 4'd1;
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    one_beat(32'h0001_0000, 32'h0);
    check_eq("post_rst_shift", 64'(last_out[7:0]), 64'h84);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_dac_fmt.md
# axis_dac_fmt

Parametrised AXI-Stream output conditioner between the FIR filter output and the 8-bit DAC. Each beat carries NUM_CH signed FIR samples. Every lane applies a fixed-plus-runtime arithmetic right shift, optional round-half-up and optional saturation, then converts to offset binary. The block is a 2-stage pipeline with full backpressure. The runtime shift is frame-coherent, and a saturating clip counter is provided.

## Interface
Parameters:
- IN_W, 32, signed input sample width per lane
- OUT_W, 8, output sample width per lane; must be a multiple of 8
- NUM_CH, 1, lanes packed per beat; lane k occupies bits [k*W +: W]
- SCALE, 12, fixed shift applied before the runtime shift
- SHIFT_W, 4, width of the runtime shift control

Ports:
- s00_axis_aclk  in  1  sole clock for the whole block
- s00_axis_aresetn  in  1  asynchronous, active-low reset
- s00_axis_tdata  in  NUM_CH*IN_W  signed input samples
- s00_axis_tvalid  in  1  input beat valid
- s00_axis_tlast  in  1  last beat of frame
- s00_axis_tready  out  1  input accepted when high with tvalid
- m00_axis_tdata  out  NUM_CH*OUT_W  offset-binary output samples
- m00_axis_tvalid  out  1  output beat valid
- m00_axis_tlast  out  1  tlast of the input beat, forwarded
- m00_axis_tstrb  out  NUM_CH*OUT_W/8  constant all ones
- m00_axis_tready  in  1  downstream ready
- shift  in  SHIFT_W  runtime shift; effective shift is shamt = SCALE + 2*shift
- round_en  in  1  enables round-half-up before the shift
- sat_en  in  1  1 = saturate, 0 = wrap (take the low OUT_W bits)
- clip_clr  in  1  synchronous clear of clip_count
- clip_count  out  16  number of beats in which at least one lane clipped

## Operation
- shift_active (SHIFT_W register):
  - Loaded from shift on every edge after which in_frame is 0.
  - in_frame sets on an accepted beat with tlast=0 and clears on an accepted beat with tlast=1.
  - Result: shift is constant within a frame. A beat accepted in cycle t uses the value of shift_active during cycle t.
- Stage 1, per lane:
  - Sign-extend x to IN_W+1 bits.
  - If round_en and shamt>0, add 2^(shamt-1).
  - Arithmetic right shift by shamt.
  - If shamt >= IN_W+1, the result is the sign of the extended value (0 or -1).
- Stage 2, per lane:
  - If sat_en: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set the lane clip flag when clamped.
  - Else: take the low OUT_W bits and set the clip flag on overflow. The flag still counts when wrapping.
  - Invert the MSB to produce offset binary.
- Clip counter:
  - clip_count increments by 1 per beat loaded into stage 2 when any lane flag is set.
  - Saturates at 0xFFFF.
  - clip_clr has priority over increment.
- round_en and sat_en are sampled per beat when that beat enters the stage that uses them; they are not frame-latched.

## Timing
- Reset values:
  - v1, v2 = 0; m00_axis_tvalid = 0; m00_axis_tdata = 0; m00_axis_tlast = 0.
  - clip_count = 0; in_frame = 0; shift_active = 0. shift_active loads shift on the first edge after reset release.
- Latency is 2 cycles from input acceptance to m00_axis_tvalid when there is no backpressure.
- Throughput is 1 beat per cycle.
- Stage advance rules:
  - adv2 = !v2 | m00_axis_tready
  - adv1 = !v1 | adv2
  - s00_axis_tready = adv1. This is a combinational path from m00_axis_tready.
- Downstream stall: with m00_axis_tready low, at most 2 beats are held. Data and tlast stay stable while tvalid is high and tready is low.
- Simultaneous events:
  - A beat leaving stage 2 while a beat enters stage 2 in the same cycle is legal and loses no data.
  - clip_clr in the same cycle as a clipping beat leaves clip_count = 0.
- Reset mid-stream discards all in-flight beats. Outputs reach their reset values immediately (asynchronous reset).

## Structure
- Package axis_dac_fmt_pkg holds:
  - CLIP_CNT_W = 16
  - MAX_SHAMT = SCALE + 2*(2^SHIFT_W - 1)
  - lane saturation/wrap helper function
- Sub-module axis_dac_fmt_lane: combinational stage-1 and stage-2 datapath for one lane, including the clip flag.
  - Instantiated NUM_CH times.
  - Pipeline registers, handshake and counter live in the top level.

## Test plan
Defaults for all scenarios unless stated otherwise: IN_W=32, OUT_W=8, NUM_CH=1, SCALE=12, shift=0.
1. Basic conversion:
   - Input 0x00001000 -> 0x81.
   - Input 0xFFFFF000 -> 0x7F.
   - Input 0 -> 0x80.
   - Each output appears 2 cycles after acceptance.
2. Saturation:
   - sat_en=1, input 0x00080000 -> 0xFF, clip_count=1.
   - Input 0xFFF00000 -> 0x00, clip_count=2.
   - sat_en=0, input 0x00080000 -> 0x00, clip_count=3.
3. Rounding: input 0x00000800 with round_en=1 -> 0x81; with round_en=0 -> 0x80.
4. Frame-coherent shift:
   - Change shift 0->2 after beat 1 of a 4-beat frame of 0x00010000.
   - All four beats -> 0x90.
   - The next frame -> 0x81.
5. Backpressure: stream 10 beats while m00_axis_tready toggles low 5 cycles out of 8. Required:
   - All 10 beats arrive in order with tlast intact.
   - s00_axis_tready is low only while both stages are full and the downstream is stalled.
6. Mixed cases:
   - NUM_CH=2: per-lane results are independent, and clip_count increments once when both lanes clip.
   - clip_clr together with a clipping beat -> clip_count=0.
   - Reset asserted mid-frame -> m00_axis_tvalid=0 immediately and in_frame=0.
